// File: rtl/game_step_if.sv
// Board-logic handshake bundle for game_step_ctrl.
//   move_req : controller -> board, one-cycle move request pulse
//   move_dir : controller -> board, one-hot direction {right,left,down,up}
//   move_ack : board -> controller, one-cycle resolution pulse
//   move_ok  : board -> controller, qualifies move_ack (1 = move executed)
//   win      : board -> controller, puzzle-solved level
interface game_step_if;
  logic       move_req;
  logic [3:0] move_dir;
  logic       move_ack;
  logic       move_ok;
  logic       win;

  modport master (output move_req, move_dir, input move_ack, move_ok, win);
  modport slave  (input move_req, move_dir, output move_ack, move_ok, win);
endinterface

// File: rtl/game_step_ctrl.sv
// Game-flow controller: debounces the six player buttons, runs the
// idle/playing/paused/won state machine, issues move requests to the board
// logic and counts accepted moves for the step display.
// Ports:
//   sys_clk, rst       : clock, asynchronous active-high reset
//   btn_start/btn_pause: raw start/restart and pause/resume buttons
//   btn_move[3:0]      : raw direction buttons {right,left,down,up}
//   bus (master)       : move_req/move_dir out, move_ack/move_ok/win in
//   steps[13:0]        : accepted move count, saturating at MAX_STEPS
//   game_status[1:0]   : 00 idle, 01 playing, 10 paused, 11 won
//   timer_en           : high while playing (including awaiting an ack)
module game_step_ctrl #(
  parameter int unsigned DEB_CYCLES  = 2000000,
  parameter int unsigned DEB_W       = 21,
  parameter int unsigned ACK_TIMEOUT = 1024,
  parameter int unsigned MAX_STEPS   = 9999
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        btn_start,
  input  logic        btn_pause,
  input  logic [3:0]  btn_move,
  game_step_if.master bus,
  output logic [13:0] steps,
  output logic [1:0]  game_status,
  output logic        timer_en
);

  localparam int unsigned NBTN    = 6;
  localparam int unsigned STEPS_W = 14;
  localparam int unsigned TMO_W   = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PLAY, S_WAIT, S_PAUSE, S_WON
  } state_t;

  // Button channel order: [0]=start, [1]=pause, [5:2]=moves
  logic [NBTN-1:0] raw;
  logic [NBTN-1:0] sync1_q, sync2_q, deb, deb_prev_q, press_q;

  assign raw = {btn_move, btn_pause, btn_start};

  // Two-flop synchronizers, edge detect on debounced level, press pulses
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_prev_q <= '0;
      press_q    <= '0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb;
      press_q    <= deb & ~deb_prev_q;
    end
  end

  // Per-channel debounce: deb follows the input only after DEB_CYCLES stable cycles
  for (genvar g = 0; g < NBTN; g++) begin : g_deb
    logic [DEB_W-1:0] cnt_q;
    logic             deb_q;

    always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
        deb_q <= 1'b0;
      end else if (sync2_q[g] == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
        cnt_q <= '0;
        deb_q <= ~deb_q;
      end else begin
        cnt_q <= cnt_q + DEB_W'(1);
      end
    end

    assign deb[g] = deb_q;
  end

  logic       start_p, pause_p;
  logic [3:0] mv, mv_sel;

  assign start_p = press_q[0];
  assign pause_p = press_q[1];
  assign mv      = press_q[5:2];
  // Isolate lowest set bit so the lowest-index direction wins
  assign mv_sel  = mv & (~mv + 4'd1);

  state_t             state_q, state_d;
  logic [STEPS_W-1:0] steps_q, steps_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               req_q, req_d;
  logic [3:0]         dir_q, dir_d;
  logic [1:0]         status_q, status_d;
  logic               ten_q, ten_d;

  // State and output registers
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      steps_q  <= '0;
      tmo_q    <= '0;
      req_q    <= 1'b0;
      dir_q    <= '0;
      status_q <= 2'b00;
      ten_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      steps_q  <= steps_d;
      tmo_q    <= tmo_d;
      req_q    <= req_d;
      dir_q    <= dir_d;
      status_q <= status_d;
      ten_q    <= ten_d;
    end
  end

  // Next-state, step counting and move request generation
  always_comb begin
    state_d = state_q;
    steps_d = steps_q;
    tmo_d   = tmo_q;
    req_d   = 1'b0;
    dir_d   = dir_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_p) state_d = S_PLAY;
      end
      S_PLAY: begin
        if (start_p) begin
          state_d = S_IDLE;
          steps_d = '0;
        end else if (pause_p) begin
          state_d = S_PAUSE;
        end else if (bus.win) begin
          state_d = S_WON;
        end else if (|mv) begin
          req_d   = 1'b1;
          dir_d   = mv_sel;
          tmo_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Timeout is checked before ack: an ack after the window is stale
        if (start_p) begin
          state_d = S_IDLE;
          steps_d = '0;
        end else if (tmo_q == TMO_W'(ACK_TIMEOUT)) begin
          state_d = S_PLAY;
        end else if (bus.move_ack) begin
          if (bus.move_ok && (steps_q < STEPS_W'(MAX_STEPS)))
            steps_d = steps_q + STEPS_W'(1);
          state_d = bus.win ? S_WON : S_PLAY;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_PAUSE: begin
        if (start_p) begin
          state_d = S_IDLE;
          steps_d = '0;
        end else if (pause_p) begin
          state_d = S_PLAY;
        end
      end
      S_WON: begin
        if (start_p) begin
          state_d = S_IDLE;
          steps_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    unique case (state_d)
      S_PLAY, S_WAIT: status_d = 2'b01;
      S_PAUSE:        status_d = 2'b10;
      S_WON:          status_d = 2'b11;
      default:        status_d = 2'b00;
    endcase
    ten_d = (state_d == S_PLAY) || (state_d == S_WAIT);
  end

  assign bus.move_req = req_q;
  assign bus.move_dir = dir_q;
  assign steps        = steps_q;
  assign game_status  = status_q;
  assign timer_en     = ten_q;

endmodule

// File: tb/tb_game_step_ctrl.sv
module tb_game_step_ctrl;
  localparam int unsigned DEB    = 4;
  localparam int unsigned TMO    = 16;
  localparam int unsigned MAXS   = 5;
  localparam int unsigned SETTLE = DEB + 8;

  logic        sys_clk = 1'b0;
  logic        rst;
  logic        btn_start, btn_pause;
  logic [3:0]  btn_move;
  logic [13:0] steps;
  logic [1:0]  game_status;
  logic        timer_en;

  game_step_if bus();

  game_step_ctrl #(
    .DEB_CYCLES(DEB), .DEB_W(4), .ACK_TIMEOUT(TMO), .MAX_STEPS(MAXS)
  ) dut (
    .sys_clk(sys_clk), .rst(rst), .btn_start(btn_start), .btn_pause(btn_pause),
    .btn_move(btn_move), .bus(bus), .steps(steps), .game_status(game_status),
    .timer_en(timer_en)
  );

  always #5 sys_clk = ~sys_clk;

  int errors = 0;
  int checks = 0;
  int req_cnt = 0;
  logic req_prev = 1'b0;

  // Counts move_req pulses and flags back-to-back requests
  always @(posedge sys_clk) begin
    #1;
    if (bus.move_req === 1'b1) begin
      checks++;
      if (req_prev !== 1'b0) begin
        errors++;
        $display("FAIL req_spacing: move_req high on consecutive cycles at %0t", $time);
      end
      req_cnt++;
    end
    req_prev = bus.move_req;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic drive_btn(input logic s, input logic p, input logic [3:0] m);
    @(negedge sys_clk);
    btn_start = s; btn_pause = p; btn_move = m;
  endtask

  task automatic release_all();
    drive_btn(1'b0, 1'b0, 4'b0000);
    tick(SETTLE);
  endtask

  task automatic tap(input logic s, input logic p, input logic [3:0] m);
    drive_btn(s, p, m);
    tick(SETTLE);
    release_all();
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    rst = 1'b1;
    btn_start = 1'b0; btn_pause = 1'b0; btn_move = 4'b0000;
    bus.move_ack = 1'b0; bus.move_ok = 1'b0; bus.win = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  // Waits for move_req; edge 1 is the first rising edge after the call
  task automatic wait_req(input int budget, output int edges, output bit found,
                          output logic [3:0] dir);
    found = 1'b0; edges = 0; dir = 4'b0000;
    for (int i = 1; i <= budget; i++) begin
      @(posedge sys_clk); #1;
      if (bus.move_req === 1'b1) begin
        found = 1'b1; edges = i; dir = bus.move_dir;
        break;
      end
    end
  endtask

  // Ack sampled d edges after the move_req edge
  task automatic send_ack(input int d, input bit ok, input bit w);
    repeat (d - 1) @(negedge sys_clk);
    @(negedge sys_clk);
    bus.move_ack = 1'b1; bus.move_ok = ok; bus.win = w;
    @(negedge sys_clk);
    bus.move_ack = 1'b0; bus.move_ok = 1'b0; bus.win = 1'b0;
  endtask

  // Press a direction mask, resolve with an ack (d=0: never ack), release
  task automatic do_move(input logic [3:0] mask, input int d, input bit ok, input bit w,
                         output bit found, output logic [3:0] dir);
    int e;
    drive_btn(1'b0, 1'b0, mask);
    wait_req(DEB + 10, e, found, dir);
    if (found) begin
      if (d == 0) tick(TMO + 3);
      else send_ack(d, ok, w);
    end
    release_all();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (steps !== 14'd0) begin errors++; $display("FAIL reset_steps: got %0d want 0", steps); end
    checks++; if (game_status !== 2'b00) begin errors++; $display("FAIL reset_status: got %b want 00", game_status); end
    checks++; if (timer_en !== 1'b0) begin errors++; $display("FAIL reset_timer: got %b want 0", timer_en); end
    checks++; if (bus.move_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", bus.move_req); end
    checks++; if (bus.move_dir !== 4'b0000) begin errors++; $display("FAIL reset_dir: got %b want 0000", bus.move_dir); end
  endtask

  task automatic test_start_move();
    int e; bit f; logic [3:0] dir;
    tap(1'b1, 1'b0, 4'b0000);
    checks++; if (game_status !== 2'b01) begin errors++; $display("FAIL start_status: got %b want 01", game_status); end
    drive_btn(1'b0, 1'b0, 4'b0001);
    wait_req(DEB + 10, e, f, dir);
    checks++; if (e !== int'(DEB + 4)) begin errors++; $display("FAIL req_latency: got edge %0d want %0d", e, DEB + 4); end
    checks++; if (dir !== 4'b0001) begin errors++; $display("FAIL req_dir_up: got %b want 0001", dir); end
    send_ack(1, 1'b1, 1'b0);
    checks++; if (steps !== 14'd1) begin errors++; $display("FAIL first_step: got %0d want 1", steps); end
    checks++; if (timer_en !== 1'b1) begin errors++; $display("FAIL play_timer: got %b want 1", timer_en); end
    release_all();
  endtask

  task automatic test_bounce();
    int c0, e; bit f; logic [3:0] dir;
    int widths[3] = '{1, 2, 3};
    c0 = req_cnt;
    foreach (widths[i]) begin
      drive_btn(1'b0, 1'b0, 4'b0001);
      repeat (widths[i] - 1) @(negedge sys_clk);
      drive_btn(1'b0, 1'b0, 4'b0000);
      tick(2);
    end
    tick(DEB + 4);
    checks++; if (req_cnt !== c0) begin errors++; $display("FAIL bounce_quiet: got %0d reqs want 0", req_cnt - c0); end
    drive_btn(1'b0, 1'b0, 4'b0001);
    wait_req(DEB + 10, e, f, dir);
    if (f) send_ack(1, 1'b1, 1'b0);
    tick(2);
    release_all();
    checks++; if (req_cnt !== c0 + 1) begin errors++; $display("FAIL bounce_one_req: got %0d reqs want 1", req_cnt - c0); end
    checks++; if (steps !== 14'd2) begin errors++; $display("FAIL bounce_steps: got %0d want 2", steps); end
  endtask

  task automatic test_illegal_timeout();
    bit f; logic [3:0] dir;
    do_move(4'b0010, 1, 1'b0, 1'b0, f, dir);
    checks++; if (dir !== 4'b0010) begin errors++; $display("FAIL illegal_dir: got %b want 0010", dir); end
    checks++; if (steps !== 14'd2) begin errors++; $display("FAIL illegal_steps: got %0d want 2", steps); end
    // Ack one edge past the window is stale
    do_move(4'b0001, TMO + 1, 1'b1, 1'b0, f, dir);
    checks++; if (f !== 1'b1) begin errors++; $display("FAIL after_illegal_req: got %b want 1", f); end
    checks++; if (steps !== 14'd2) begin errors++; $display("FAIL late_ack_steps: got %0d want 2", steps); end
    // Ack on the last edge of the window still counts
    do_move(4'b0001, TMO, 1'b1, 1'b0, f, dir);
    checks++; if (f !== 1'b1) begin errors++; $display("FAIL after_timeout_req: got %b want 1", f); end
    checks++; if (steps !== 14'd3) begin errors++; $display("FAIL edge_ack_steps: got %0d want 3", steps); end
    checks++; if (game_status !== 2'b01) begin errors++; $display("FAIL timeout_status: got %b want 01", game_status); end
  endtask

  task automatic test_pause();
    bit f; logic [3:0] dir; int c0;
    tap(1'b0, 1'b1, 4'b0000);
    checks++; if (game_status !== 2'b10) begin errors++; $display("FAIL pause_status: got %b want 10", game_status); end
    checks++; if (timer_en !== 1'b0) begin errors++; $display("FAIL pause_timer: got %b want 0", timer_en); end
    do_move(4'b0001, 1, 1'b1, 1'b0, f, dir);
    checks++; if (f !== 1'b0) begin errors++; $display("FAIL pause_move: got req %b want 0", f); end
    tap(1'b0, 1'b1, 4'b0000);
    checks++; if (game_status !== 2'b01) begin errors++; $display("FAIL resume_status: got %b want 01", game_status); end
    c0 = req_cnt;
    tap(1'b0, 1'b1, 4'b0100);
    checks++; if (game_status !== 2'b10) begin errors++; $display("FAIL simul_status: got %b want 10", game_status); end
    checks++; if (req_cnt !== c0) begin errors++; $display("FAIL simul_req: got %0d reqs want 0", req_cnt - c0); end
    tap(1'b0, 1'b1, 4'b0000);
    checks++; if (timer_en !== 1'b1) begin errors++; $display("FAIL resume2_timer: got %b want 1", timer_en); end
    do_move(4'b1100, 1, 1'b1, 1'b0, f, dir);
    checks++; if (dir !== 4'b0100) begin errors++; $display("FAIL multi_dir: got %b want 0100", dir); end
    checks++; if (steps !== 14'd4) begin errors++; $display("FAIL multi_steps: got %0d want 4", steps); end
  endtask

  task automatic test_win_sat();
    bit f; logic [3:0] dir;
    do_reset();
    tap(1'b1, 1'b0, 4'b0000);
    for (int i = 0; i < int'(MAXS) + 1; i++) do_move(4'b1000, 1, 1'b1, 1'b0, f, dir);
    checks++; if (steps !== 14'(MAXS)) begin errors++; $display("FAIL sat_steps: got %0d want %0d", steps, MAXS); end
    do_move(4'b0001, 2, 1'b1, 1'b1, f, dir);
    checks++; if (steps !== 14'(MAXS)) begin errors++; $display("FAIL win_steps: got %0d want %0d", steps, MAXS); end
    checks++; if (game_status !== 2'b11) begin errors++; $display("FAIL win_status: got %b want 11", game_status); end
    checks++; if (timer_en !== 1'b0) begin errors++; $display("FAIL win_timer: got %b want 0", timer_en); end
    do_move(4'b0001, 1, 1'b1, 1'b0, f, dir);
    checks++; if (f !== 1'b0) begin errors++; $display("FAIL won_move: got req %b want 0", f); end
    tap(1'b0, 1'b1, 4'b0000);
    checks++; if (game_status !== 2'b11) begin errors++; $display("FAIL won_pause: got %b want 11", game_status); end
    tap(1'b1, 1'b0, 4'b0000);
    checks++; if (game_status !== 2'b00) begin errors++; $display("FAIL won_restart_status: got %b want 00", game_status); end
    checks++; if (steps !== 14'd0) begin errors++; $display("FAIL won_restart_steps: got %0d want 0", steps); end
  endtask

  task automatic test_reset_in_wait();
    int e, c0; bit f; logic [3:0] dir;
    tap(1'b1, 1'b0, 4'b0000);
    do_move(4'b0001, 1, 1'b1, 1'b0, f, dir);
    drive_btn(1'b0, 1'b0, 4'b0010);
    wait_req(DEB + 10, e, f, dir);
    @(posedge sys_clk); #2;
    rst = 1'b1;
    #1;
    checks++; if (steps !== 14'd0) begin errors++; $display("FAIL rstw_steps: got %0d want 0", steps); end
    checks++; if (game_status !== 2'b00) begin errors++; $display("FAIL rstw_status: got %b want 00", game_status); end
    checks++; if (timer_en !== 1'b0) begin errors++; $display("FAIL rstw_timer: got %b want 0", timer_en); end
    checks++; if (bus.move_dir !== 4'b0000) begin errors++; $display("FAIL rstw_dir: got %b want 0000", bus.move_dir); end
    tick(2);
    rst = 1'b0;
    c0 = req_cnt;
    send_ack(1, 1'b1, 1'b0);
    tick(SETTLE);
    release_all();
    checks++; if (steps !== 14'd0) begin errors++; $display("FAIL late_ack_ignored: got %0d want 0", steps); end
    checks++; if (game_status !== 2'b00) begin errors++; $display("FAIL post_rst_status: got %b want 00", game_status); end
    checks++; if (req_cnt !== c0) begin errors++; $display("FAIL post_rst_req: got %0d reqs want 0", req_cnt - c0); end
  endtask

  // Random press/ack sequence against an abstract game model
  task automatic test_random();
    int m_st, m_steps, op, d, r;
    bit ok, w, f;
    logic [3:0] mask, dir, exp_dir;
    do_reset();
    m_st = 0; m_steps = 0;   // 0 idle, 1 playing, 2 paused, 3 won
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 5);
      if (op == 0) begin
        tap(1'b1, 1'b0, 4'b0000);
        if (m_st == 0) m_st = 1;
        else begin m_st = 0; m_steps = 0; end
      end else if (op == 1) begin
        tap(1'b0, 1'b1, 4'b0000);
        if (m_st == 1) m_st = 2;
        else if (m_st == 2) m_st = 1;
      end else begin
        mask = 4'($urandom_range(1, 15));
        exp_dir = 4'b0000;
        for (int i = 0; i < 4; i++) if (mask[i]) begin exp_dir[i] = 1'b1; break; end
        r  = $urandom_range(0, 3);
        d  = (r == 0) ? 0 : $urandom_range(1, 4);
        ok = 1'($urandom_range(0, 1));
        w  = ($urandom_range(0, 4) == 0);
        do_move(mask, d, ok, w, f, dir);
        checks++; if (f !== (m_st == 1)) begin errors++; $display("FAIL rnd_req[%0d]: got %b want %b", n, f, m_st == 1); end
        if (m_st == 1) begin
          checks++; if (dir !== exp_dir) begin errors++; $display("FAIL rnd_dir[%0d]: got %b want %b", n, dir, exp_dir); end
          if (d != 0) begin
            if (ok && m_steps < int'(MAXS)) m_steps++;
            m_st = w ? 3 : 1;
          end
        end
      end
      checks++; if (game_status !== 2'(m_st)) begin errors++; $display("FAIL rnd_status[%0d]: got %b want %b", n, game_status, 2'(m_st)); end
      checks++; if (steps !== 14'(m_steps)) begin errors++; $display("FAIL rnd_steps[%0d]: got %0d want %0d", n, steps, m_steps); end
      checks++; if (timer_en !== (m_st == 1)) begin errors++; $display("FAIL rnd_timer[%0d]: got %b want %b", n, timer_en, m_st == 1); end
    end
  endtask

  initial begin
    rst = 1'b1;
    btn_start = 1'b0; btn_pause = 1'b0; btn_move = 4'b0000;
    bus.move_ack = 1'b0; bus.move_ok = 1'b0; bus.win = 1'b0;
    test_reset();
    test_start_move();
    test_bounce();
    test_illegal_timeout();
    test_pause();
    test_random();
    test_win_sat();
    test_reset_in_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/game_step_ctrl.md
# game_step_ctrl

Game-flow controller that sits directly upstream of the seven-segment time/step display block. It debounces the six player buttons and runs the game state machine (idle / playing / paused / won). It issues one-hot move requests to the board logic and counts accepted moves. Its outputs `steps`, `game_status` and `timer_en` drive the display stage's step digits, timer clear and timer gating.

## Interface
Parameters:
- `DEB_CYCLES`, default 2000000: consecutive stable cycles required to accept a button level change (20 ms at 100 MHz).
- `DEB_W`, default 21: width of each debounce counter; must hold `DEB_CYCLES-1`.
- `ACK_TIMEOUT`, default 1024: cycles to wait for `move_ack` before abandoning a move.
- `MAX_STEPS`, default 9999: saturation value of `steps`.

Ports:
- `sys_clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `btn_start` in 1: raw start/restart button, asynchronous, active-high.
- `btn_pause` in 1: raw pause/resume button.
- `btn_move` in 4: raw direction buttons; [0]=up, [1]=down, [2]=left, [3]=right.
- `move_ack` in 1: one-cycle pulse from board logic; the move request is resolved.
- `move_ok` in 1: qualifies `move_ack`; 1 = move was legal and was executed.
- `win` in 1: level signal from board logic; puzzle solved.
- `move_req` out 1: one-cycle pulse requesting a move.
- `move_dir` out 4: one-hot direction, valid while `move_req`=1; held until the next request.
- `steps` out 14: accepted move count, binary, 0..`MAX_STEPS`.
- `game_status` out 2: 00 idle, 01 playing, 10 paused, 11 won.
- `timer_en` out 1: 1 only while playing.

## Operation
- **Per-button conditioning (6 identical channels):**
  - 2-flop synchronizer, then debounce counter against the debounced level `deb`.
  - The counter increments while the synchronized input differs from `deb`, and clears when they are equal.
  - When the counter reaches `DEB_CYCLES-1` and the inputs still differ, `deb` toggles and the counter clears.
  - A registered press pulse is produced on each 0->1 transition of `deb`. Release generates nothing.
- **FSM states:**
  - IDLE (status 00)
  - PLAY (01)
  - WAIT (01; awaiting ack)
  - PAUSE (10)
  - WON (11)
- **Press priority in one cycle:** start > pause > move. Among moves, the lowest index wins. Losing presses in that cycle are discarded.
- **IDLE:**
  - start -> PLAY; `steps` stays 0.
  - All other presses are ignored.
- **PLAY:**
  - start -> IDLE, and `steps` clears.
  - pause -> PAUSE.
  - move -> pulse `move_req` with `move_dir`, clear the timeout counter, go to WAIT.
  - If `win`=1 while in PLAY (no request pending) -> WON.
- **WAIT:**
  - `move_ack` with `move_ok`=1: `steps`+1 (saturating at `MAX_STEPS`).
  - `move_ack` with `move_ok`=0: `steps` unchanged.
  - After `move_ack`: `win`=1 sampled in the ack cycle -> WON, else -> PLAY.
  - No ack within `ACK_TIMEOUT` cycles after the request -> PLAY, no step counted.
  - start -> IDLE; `steps` clears and the pending ack is ignored.
  - pause and move presses are discarded.
  - `move_ack` outside WAIT is ignored.
- **PAUSE:**
  - pause -> PLAY.
  - start -> IDLE; `steps` clears.
  - Moves are discarded.
- **WON:**
  - Only start -> IDLE; `steps` clears.
  - `steps` is frozen at its final value until then.
- **Derived outputs:** `timer_en` = state is PLAY or WAIT. `game_status` is registered and decoded from the state.
- **Reset:**
  - Asynchronous; effective mid-operation with no completion of a pending request.
  - Reset values: state IDLE, `steps`=0, `game_status`=00, `timer_en`=0, `move_req`=0, `move_dir`=0000.
  - All synchronizers, `deb` levels and counters are 0.
  - A button held through reset release yields one press after debounce.

## Timing
- All outputs are registered.
- **Raw edge to press:** if a raw button edge is first sampled at edge k, `deb` changes at edge k+1+`DEB_CYCLES` and the press pulse is high for cycle k+2+`DEB_CYCLES`.
- **Press to action:** the state change or `move_req` appears one edge after the press pulse, i.e. `DEB_CYCLES`+3 edges after the raw edge.
- **Bounce:** glitches shorter than `DEB_CYCLES` cycles produce no press and no change of `deb`.
- **Ack to outputs:** `steps` and `game_status` update on the edge following the `move_ack` cycle.
- **Earliest ack:** `move_ack` may arrive as early as the cycle after `move_req`.
- **Timeout:** counted from the `move_req` cycle; PLAY is entered on edge `ACK_TIMEOUT`+1 after the request.
- **Move rate:** at most one `move_req` per ack/timeout resolution; `move_req` is never high on consecutive cycles.

## Test plan
1. `DEB_CYCLES`=4. Sequence: reset, press start, press up, then `move_ack`/`move_ok`=1 one cycle after `move_req`.
   - Status 00->01.
   - `move_req` with `move_dir`=0001, 7 edges after the raw up edge.
   - `steps`=1 and `timer_en`=1.
2. Bounce: raw up toggles with high widths of 1, 2 and 3 cycles, then holds high for 10 cycles.
   - Exactly one `move_req`.
   - No request during the bounce phase.
3. Illegal move and timeout:
   - ack with `move_ok`=0 -> `steps` unchanged and back to PLAY.
   - Next request with no ack, `ACK_TIMEOUT`=16 -> PLAY entered on edge 17 after the request; `steps` unchanged.
4. Pause and simultaneous presses:
   - pause -> status 10, `timer_en`=0, move presses produce no `move_req`.
   - pause and left pressed in the same cycle from PLAY -> PAUSE, no request.
   - pause again -> status 01.
5. Win and saturation:
   - Preload `steps` to 9998 via 9998 ok-acks (small `MAX_STEPS`=5 variant also acceptable).
   - Next ok-ack with `win`=1 -> `steps`=9999, status 11.
   - Further moves ignored; start -> status 00, `steps`=0.
6. Reset in WAIT:
   - Assert `rst` one cycle after `move_req` -> all outputs 0 immediately.
   - A late `move_ack` after reset release is ignored (`steps`=0, status 00).
